// File: rtl/muldiv_hilo.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Signed ops run on magnitudes; the sign is corrected in FIN before HI/LO are written.
`timescale 1ns/1ps

module muldiv_hilo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_divz;
    logic [31:0] r_a_raw;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_sum;
    logic [32:0] w_part;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [63:0] w_prod;
    logic [31:0] w_quo_fin;
    logic [31:0] w_rem_fin;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_cnt == 5'd31) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a_in[31];
    assign w_b_neg  = w_signed & b_in[31];
    assign w_a_mag  = w_a_neg ? (~a_in + 32'd1) : a_in;
    assign w_b_mag  = w_b_neg ? (~b_in + 32'd1) : b_in;

    // Multiply keeps the multiplier in the low half of the accumulator and shifts it out.
    assign w_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);

    // Restoring divide: 33-bit partial remainder compared against the divisor.
    assign w_part = {r_rem, r_quo[31]};
    assign w_ge   = (w_part >= {1'b0, r_b});
    assign w_diff = w_part[31:0] - r_b;

    assign w_prod    = r_neg_res ? (~r_acc + 64'd1) : r_acc;
    assign w_quo_fin = r_neg_res ? (~r_quo + 32'd1) : r_quo;
    assign w_rem_fin = r_neg_rem ? (~r_rem + 32'd1) : r_rem;

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_is_div) begin
            if (r_divz) begin
                w_res_hi = r_a_raw;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = w_rem_fin;
                w_res_lo = w_quo_fin;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 5'd0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_divz    <= 1'b0;
            r_a_raw   <= 32'd0;
            r_b       <= 32'd0;
            r_acc     <= 64'd0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIN);
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_cnt     <= 5'd0;
                        r_is_div  <= op[1];
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_divz    <= (b_in == 32'd0);
                        r_a_raw   <= a_in;
                        r_b       <= w_b_mag;
                        r_acc     <= {32'd0, w_a_mag};
                        r_rem     <= 32'd0;
                        r_quo     <= w_a_mag;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 5'd1;
                    r_acc <= {w_sum, r_acc[31:1]};
                    r_rem <= w_ge ? w_diff : w_part[31:0];
                    r_quo <= {r_quo[30:0], w_ge};
                end
                S_FIN: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: expected HI/LO pairs are queued at issue
// and popped by a monitor whenever done pulses.
`timescale 1ns/1ps

module tb_muldiv_hilo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a_in = 32'd0;
    logic [31:0] b_in = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    muldiv_hilo dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a_in  (a_in),
        .b_in  (b_in),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Each done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done got hi=%h lo=%h, expected no result", hi, lo);
            end else begin
                logic [63:0] exp;
                exp = sb_q.pop_front();
                if ({hi, lo} !== exp) begin
                    errors++;
                    $display("[TB] FAIL result got hi=%h lo=%h, expected hi=%h lo=%h",
                             hi, lo, exp[63:32], exp[31:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired, simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'd0: p = sa * sb;
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Called at a negedge; returns one negedge later with start dropped and operands scrambled.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        op    = o;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
    endtask

    task automatic wait_done(output int waited, output int nbusy);
        waited = 0;
        nbusy  = 0;
        while (done !== 1'b1 && waited < 80) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            waited++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_timeout got done=%b after %0d cycles, expected 1", done, waited);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done); end
        if (hi !== 32'd0)  begin errors++; $display("[TB] FAIL reset_hi got %h expected 0", hi); end
        if (lo !== 32'd0)  begin errors++; $display("[TB] FAIL reset_lo got %h expected 0", lo); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu();
        int w, nb;
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
        wait_done(w, nb);
        checks += 2;
        if (w !== 33)  begin errors++; $display("[TB] FAIL multu_latency got %0d expected 33", w); end
        if (nb !== 33) begin errors++; $display("[TB] FAIL multu_busy_cycles got %0d expected 33", nb); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_width got %b expected 0", done); end
    endtask

    task automatic test_signed();
        int w, nb;
        issue(2'd0, 32'hFFFF_FFF9, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        wait_done(w, nb);
        @(negedge clk);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_done(w, nb);
        @(negedge clk);
    endtask

    task automatic test_div_edge();
        int w, nb;
        issue(2'd3, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF});
        wait_done(w, nb);
        checks++;
        if (w !== 33) begin errors++; $display("[TB] FAIL divz_latency got %0d expected 33", w); end
        @(negedge clk);
        issue(2'd2, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        wait_done(w, nb);
        @(negedge clk);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        wait_done(w, nb);
        @(negedge clk);
    endtask

    task automatic test_stall();
        int w, nb, extra;
        issue(2'd3, 32'd50, 32'd7, {32'd1, 32'd7});
        repeat (9) @(negedge clk);
        op    = 2'd1;
        a_in  = 32'd2;
        b_in  = 32'd3;
        wdata = 32'h1234;
        hi_we = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        checks++;
        if (hi !== 32'd0 && hi === 32'h1234) begin
            errors++;
            $display("[TB] FAIL stall_mthi got hi=%h, expected no write while busy", hi);
        end
        wait_done(w, nb);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks += 2;
        if (extra !== 0) begin errors++; $display("[TB] FAIL stall_extra_done got %0d expected 0", extra); end
        if (hi !== 32'd1) begin errors++; $display("[TB] FAIL stall_hi_hold got %h expected 1", hi); end
    endtask

    task automatic test_back_to_back();
        int w, nb;
        issue(2'd1, 32'd12345, 32'd6789, model(2'd1, 32'd12345, 32'd6789));
        wait_done(w, nb);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_at_done got %b expected 0", busy); end
        issue(2'd2, 32'hFFFF_FC00, 32'd7, model(2'd2, 32'hFFFF_FC00, 32'd7));
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept got busy=%b expected 1", busy); end
        wait_done(w, nb);
        checks++;
        if (w !== 33) begin errors++; $display("[TB] FAIL b2b_latency got %0d expected 33", w); end
        @(negedge clk);
    endtask

    task automatic test_mt();
        int w, nb;
        wdata = 32'hDEAD_BEEF;
        hi_we = 1'b1;
        lo_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        checks += 2;
        if (hi !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL mthi got %h expected deadbeef", hi); end
        if (lo !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL mtlo got %h expected deadbeef", lo); end
        wdata = 32'h0BAD_F00D;
        hi_we = 1'b1;
        lo_we = 1'b1;
        issue(2'd1, 32'd3, 32'd5, {32'd0, 32'd15});
        hi_we = 1'b0;
        lo_we = 1'b0;
        checks += 3;
        if (hi !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL mt_start_hi got %h expected 0badf00d", hi); end
        if (lo !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL mt_start_lo got %h expected 0badf00d", lo); end
        if (busy !== 1'b1)        begin errors++; $display("[TB] FAIL mt_start_busy got %b expected 1", busy); end
        wait_done(w, nb);
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int w, nb, extra;
        wdata = 32'hA5A5_A5A5;
        hi_we = 1'b1;
        lo_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        issue(2'd0, 32'hFFFF_FFF9, 32'd3, 64'd0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb_q.pop_back());
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrun_busy got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrun_done got %b expected 0", done); end
        if (hi !== 32'd0)  begin errors++; $display("[TB] FAIL midrun_hi got %h expected 0", hi); end
        if (lo !== 32'd0)  begin errors++; $display("[TB] FAIL midrun_lo got %h expected 0", lo); end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("[TB] FAIL midrun_ghost_done got %0d expected 0", extra); end
        issue(2'd0, 32'hFFFF_FFF9, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        wait_done(w, nb);
        @(negedge clk);
    endtask

    task automatic test_random();
        int w, nb;
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i == 7) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            if (i % 3 == 0) b = ~b + 32'd1;
            issue(o, a, b, model(o, a, b));
            wait_done(w, nb);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_signed();
        test_div_edge();
        test_stall();
        test_back_to_back();
        test_mt();
        test_reset_midrun();
        test_random();
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d pending, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
